// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge capture into a pending register,
// CPU-writable mask, fixed lowest-index-first priority, and a
// request/acknowledge/end-of-interrupt handshake with the CPU.
module interrupt_controller #(
  parameter int                 LINES      = 16,
  parameter int                 CODE_WIDTH = 4,
  parameter logic [LINES-1:0]   MASK_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINES-1:0]      requests,
  input  logic                  mask_we,
  input  logic [LINES-1:0]      mask_wdata,
  input  logic                  intr_ack,
  input  logic                  intr_done,
  output logic                  intr,
  output logic [CODE_WIDTH-1:0] intr_code,
  output logic                  in_service,
  output logic [LINES-1:0]      pending,
  output logic [LINES-1:0]      mask
);

  typedef enum logic [1:0] {
    IDLE,
    REQUESTING,
    SERVICING
  } state_t;

  state_t                state_q;
  logic [LINES-1:0]      prevReq_q;
  logic [LINES-1:0]      pending_q;
  logic [LINES-1:0]      pending_d;
  logic [LINES-1:0]      mask_q;
  logic                  intr_q;
  logic                  inService_q;
  logic [CODE_WIDTH-1:0] intrCode_q;

  logic [LINES-1:0]      rise;
  logic [LINES-1:0]      eligible;
  logic [LINES-1:0]      clr;
  logic [CODE_WIDTH-1:0] winner;
  logic                  ackTaken;

  assign rise     = requests & ~prevReq_q;
  assign eligible = pending_q & mask_q;
  assign ackTaken = (state_q == REQUESTING) && intr_ack;

  // Priority pick: scanning from the top down lets the lowest set bit win.
  always_comb begin
    winner = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CODE_WIDTH'(i);
    end
  end

  // Clear only the accepted line; a rise on that line in the same cycle wins.
  always_comb begin
    clr = '0;
    if (ackTaken) clr[intrCode_q] = 1'b1;
    pending_d = (pending_q & ~clr) | rise;
  end

  // Edge-detect history, pending capture and mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevReq_q <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RESET;
    end else begin
      prevReq_q <= requests;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  // Handshake FSM with registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      intr_q      <= 1'b0;
      intrCode_q  <= '0;
      inService_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            intrCode_q <= winner;
            intr_q     <= 1'b1;
            state_q    <= REQUESTING;
          end
        end
        REQUESTING: begin
          if (intr_ack) begin
            intr_q      <= 1'b0;
            inService_q <= 1'b1;
            state_q     <= SERVICING;
          end
        end
        SERVICING: begin
          if (intr_done) begin
            inService_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          intr_q      <= 1'b0;
          inService_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign intr       = intr_q;
  assign intr_code  = intrCode_q;
  assign in_service = inService_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: expected output snapshots are
// queued as stimulus is applied and compared after the following clock edge.
module tb_interrupt_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] requests;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        intr_ack;
  logic        intr_done;
  logic        intr;
  logic [3:0]  intr_code;
  logic        in_service;
  logic [15:0] pending;
  logic [15:0] mask;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    string       tag;
    logic        intr;
    logic [3:0]  code;
    logic        inSvc;
    logic [15:0] pend;
    logic [15:0] mask;
  } exp_t;

  exp_t expQ[$];

  interrupt_controller #(
    .LINES(16),
    .CODE_WIDTH(4),
    .MASK_RESET(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .requests(requests),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .intr_ack(intr_ack),
    .intr_done(intr_done),
    .intr(intr),
    .intr_code(intr_code),
    .in_service(in_service),
    .pending(pending),
    .mask(mask)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue the outputs expected once the next edge has been taken.
  task automatic applyStimulus(input string tag, input logic eIntr, input logic [3:0] eCode,
                               input logic eSvc, input logic [15:0] ePend,
                               input logic [15:0] eMask);
    exp_t e;
    e.tag = tag; e.intr = eIntr; e.code = eCode;
    e.inSvc = eSvc; e.pend = ePend; e.mask = eMask;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic compareNow();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".intr"},  {31'd0, intr},       {31'd0, e.intr});
      checkOutput({e.tag, ".code"},  {28'd0, intr_code},  {28'd0, e.code});
      checkOutput({e.tag, ".insvc"}, {31'd0, in_service}, {31'd0, e.inSvc});
      checkOutput({e.tag, ".pend"},  {16'd0, pending},    {16'd0, e.pend});
      checkOutput({e.tag, ".mask"},  {16'd0, mask},       {16'd0, e.mask});
    end
  endtask

  // Advance one edge and sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    compareNow();
  endtask

  initial begin
    rst_n      = 1'b0;
    requests   = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    intr_ack   = 1'b0;
    intr_done  = 1'b0;

    #12;
    applyStimulus("reset", 0, 0, 0, 16'h0000, 16'h0000);
    compareNow();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pulse on line 2 with lines 0..3 enabled.
    mask_we = 1; mask_wdata = 16'h000F;
    applyStimulus("t1_mask", 0, 0, 0, 16'h0000, 16'h000F); tick();
    mask_we = 0; requests = 16'h0004;
    applyStimulus("t1_pend", 0, 0, 0, 16'h0004, 16'h000F); tick();
    requests = 16'h0000;
    applyStimulus("t1_intr", 1, 2, 0, 16'h0004, 16'h000F); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t1_hold", 1, 2, 0, 16'h0004, 16'h000F); tick();
    end
    intr_ack = 1;
    applyStimulus("t1_ack", 0, 2, 1, 16'h0000, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t1_done", 0, 2, 0, 16'h0000, 16'h000F); tick();
    intr_done = 0;

    // Simultaneous rises on lines 3 and 1: line 1 first, then line 3.
    requests = 16'h000A;
    applyStimulus("t2_pend", 0, 2, 0, 16'h000A, 16'h000F); tick();
    requests = 16'h0000;
    applyStimulus("t2_intr1", 1, 1, 0, 16'h000A, 16'h000F); tick();
    intr_ack = 1;
    applyStimulus("t2_ack1", 0, 1, 1, 16'h0008, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t2_done1", 0, 1, 0, 16'h0008, 16'h000F); tick();
    intr_done = 0;
    applyStimulus("t2_intr3", 1, 3, 0, 16'h0008, 16'h000F); tick();
    intr_ack = 1;
    applyStimulus("t2_ack3", 0, 3, 1, 16'h0000, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t2_done3", 0, 3, 0, 16'h0000, 16'h000F); tick();
    intr_done = 0;

    // Masked line stays pending until enabled.
    mask_we = 1; mask_wdata = 16'h0000;
    applyStimulus("t3_mask0", 0, 3, 0, 16'h0000, 16'h0000); tick();
    mask_we = 0; requests = 16'h0001;
    applyStimulus("t3_pend", 0, 3, 0, 16'h0001, 16'h0000); tick();
    requests = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("t3_masked", 0, 3, 0, 16'h0001, 16'h0000); tick();
    end
    mask_we = 1; mask_wdata = 16'h0001;
    applyStimulus("t3_wr", 0, 3, 0, 16'h0001, 16'h0001); tick();
    mask_we = 0;
    applyStimulus("t3_intr", 1, 0, 0, 16'h0001, 16'h0001); tick();
    intr_ack = 1;
    applyStimulus("t3_ack", 0, 0, 1, 16'h0000, 16'h0001); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t3_done", 0, 0, 0, 16'h0000, 16'h0001); tick();
    intr_done = 0;
    mask_we = 1; mask_wdata = 16'h000F;
    applyStimulus("t3_maskF", 0, 0, 0, 16'h0000, 16'h000F); tick();
    mask_we = 0;

    // Level held for 20 cycles produces one event only.
    requests = 16'h0002;
    applyStimulus("t4_pend", 0, 0, 0, 16'h0002, 16'h000F); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t4_intr", 1, 1, 0, 16'h0002, 16'h000F); tick();
    end
    intr_ack = 1;
    applyStimulus("t4_ack", 0, 1, 1, 16'h0000, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t4_done", 0, 1, 0, 16'h0000, 16'h000F); tick();
    intr_done = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus("t4_level", 0, 1, 0, 16'h0000, 16'h000F); tick();
    end
    requests = 16'h0000;
    applyStimulus("t4_release", 0, 1, 0, 16'h0000, 16'h000F); tick();

    // Rise on the acknowledged line in the ack cycle keeps it pending.
    requests = 16'h0002;
    applyStimulus("t4b_pend", 0, 1, 0, 16'h0002, 16'h000F); tick();
    requests = 16'h0000;
    applyStimulus("t4b_intr", 1, 1, 0, 16'h0002, 16'h000F); tick();
    requests = 16'h0002; intr_ack = 1;
    applyStimulus("t4b_ackrise", 0, 1, 1, 16'h0002, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t4b_done", 0, 1, 0, 16'h0002, 16'h000F); tick();
    intr_done = 0;
    applyStimulus("t4b_resig", 1, 1, 0, 16'h0002, 16'h000F); tick();

    // Stray handshakes are ignored.
    intr_ack = 1; intr_done = 1;
    applyStimulus("t5_ackdone", 0, 1, 1, 16'h0000, 16'h000F); tick();
    intr_done = 0;
    applyStimulus("t5_strayack", 0, 1, 1, 16'h0000, 16'h000F); tick();
    intr_ack = 0; intr_done = 1;
    applyStimulus("t5_done", 0, 1, 0, 16'h0000, 16'h000F); tick();
    applyStimulus("t5_straydone", 0, 1, 0, 16'h0000, 16'h000F); tick();
    intr_done = 0;
    requests = 16'h0000;
    applyStimulus("t5_idle", 0, 1, 0, 16'h0000, 16'h000F); tick();
    requests = 16'h0004;
    applyStimulus("t5_pend", 0, 1, 0, 16'h0004, 16'h000F); tick();
    applyStimulus("t5_intr", 1, 2, 0, 16'h0004, 16'h000F); tick();
    intr_ack = 1;
    applyStimulus("t5_ack", 0, 2, 1, 16'h0000, 16'h000F); tick();
    intr_ack = 0; requests = 16'h0024;
    applyStimulus("t5_nonest", 0, 2, 1, 16'h0020, 16'h000F); tick();

    // Asynchronous reset in the middle of servicing.
    #2;
    rst_n = 1'b0;
    #1;
    applyStimulus("t6_async", 0, 0, 0, 16'h0000, 16'h0000);
    compareNow();
    requests = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t6_after", 0, 0, 0, 16'h0000, 16'h0000); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
